// File: rtl/op_entry_sequencer_pkg.sv
// Shared definitions for op_entry_sequencer: 7-seg character codes and the
// sequencer state encoding. The testbench imports this package as well, so
// display expectations are written with the same names as the RTL uses.
package op_entry_sequencer_pkg;

    // 5-bit character codes understood by the 7-seg scanner.
    // Codes 0x00..0x0F are the hex digits themselves (identity mapping).
    localparam logic [4:0] CHAR_0     = 5'h00;
    localparam logic [4:0] CHAR_A     = 5'h0A;
    localparam logic [4:0] CHAR_C     = 5'h0C;
    localparam logic [4:0] CHAR_D     = 5'h0D;
    localparam logic [4:0] CHAR_E     = 5'h0E;
    localparam logic [4:0] CHAR_F     = 5'h0F;
    localparam logic [4:0] CHAR_N     = 5'h10;
    localparam logic [4:0] CHAR_R     = 5'h11;
    localparam logic [4:0] CHAR_L     = 5'h12;
    localparam logic [4:0] CHAR_H     = 5'h13;
    localparam logic [4:0] CHAR_BLANK = 5'h14;
    localparam logic [4:0] CHAR_I     = 5'h15;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_LOAD   = 3'd1,
        S_CONF   = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4,
        S_ERR    = 3'd5,
        S_READY  = 3'd6
    } state_e;

endpackage

// File: rtl/op_entry_sequencer.sv
// op_entry_sequencer: front-panel sequencer between debounced buttons /
// switches and an ALU core plus 7-seg scanner. Operands are entered through
// the switches one SW_W chunk at a time (high chunk first), then a
// configuration word is captured, the ALU is started and the result is paged
// onto the LEDs and display. A back button steps to the previous chunk and a
// timer aborts to an error state if the ALU never answers.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_next, btn_back  1-cycle button pulses (both together are ignored)
//   sw                  data chunk / configuration / result page select
//   alu_done,alu_result ALU handshake, honoured only while busy
//   ops                 operand bus, operand A in the LSBs
//   conf                captured configuration
//   alu_start           1-cycle start pulse on the first EXEC cycle
//   led                 selected result page in RESULT, else 0
//   disp                {d3,d2,d1,d0} 5-bit character codes
//   show_result, busy   state indicators (RESULT, EXEC)
module op_entry_sequencer
    import op_entry_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SW_W    = 16,
    parameter int N_OPS   = 2,
    parameter int CONF_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_next,
    input  logic                    btn_back,
    input  logic [SW_W-1:0]         sw,
    input  logic                    alu_done,
    input  logic [DATA_W-1:0]       alu_result,
    output logic [N_OPS*DATA_W-1:0] ops,
    output logic [CONF_W-1:0]       conf,
    output logic                    alu_start,
    output logic [SW_W-1:0]         led,
    output logic [19:0]             disp,
    output logic                    show_result,
    output logic                    busy
);

    localparam int CHUNKS = DATA_W / SW_W;
    localparam int PAGE_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int OP_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [PAGE_W-1:0] TOP_CHUNK = PAGE_W'(CHUNKS - 1);
    localparam logic [OP_W-1:0]   LAST_OP   = OP_W'(N_OPS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [N_OPS*DATA_W-1:0]   ops_q, ops_d;
    logic [CONF_W-1:0]         conf_q, conf_d;
    logic [DATA_W-1:0]         result_q, result_d;
    logic [PAGE_W-1:0]         chunk_q, chunk_d;
    logic [OP_W-1:0]           op_q, op_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      alu_start_q, alu_start_d;
    logic [PAGE_W-1:0]         page_q, page_d;

    logic                      go_next, go_back;
    logic [PAGE_W-1:0]         page_sel;
    logic [SW_W-1:0]           page_data;
    logic [15:0]               page_nib;
    logic [4:0]                load_tag;

    // A simultaneous next+back is treated as no press at all.
    assign go_next  = btn_next & ~btn_back;
    assign go_back  = btn_back & ~btn_next;
    assign page_sel = sw[SW_W-1 -: PAGE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            ops_q       <= '0;
            conf_q      <= '0;
            result_q    <= '0;
            chunk_q     <= '0;
            op_q        <= '0;
            timer_q     <= '0;
            alu_start_q <= 1'b0;
            page_q      <= '0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            conf_q      <= conf_d;
            result_q    <= result_d;
            chunk_q     <= chunk_d;
            op_q        <= op_d;
            timer_q     <= timer_d;
            alu_start_q <= alu_start_d;
            page_q      <= page_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        conf_d      = conf_q;
        result_d    = result_q;
        chunk_d     = chunk_q;
        op_d        = op_q;
        timer_d     = timer_q;
        alu_start_d = 1'b0;
        // Page select is registered every cycle so led/disp stay register-driven;
        // out-of-range pages clamp to the top chunk.
        page_d      = (int'(page_sel) > CHUNKS - 1) ? TOP_CHUNK : page_sel;

        case (state_q)
            S_OFF, S_READY: begin
                if (go_next) begin
                    state_d = S_LOAD;
                    op_d    = '0;
                    chunk_d = TOP_CHUNK;
                end
            end
            S_LOAD: begin
                if (go_next) begin
                    ops_d[int'(op_q)*DATA_W + int'(chunk_q)*SW_W +: SW_W] = sw;
                    if (chunk_q != '0) begin
                        chunk_d = chunk_q - 1'b1;
                    end else if (op_q != LAST_OP) begin
                        op_d    = op_q + 1'b1;
                        chunk_d = TOP_CHUNK;
                    end else begin
                        state_d = S_CONF;
                    end
                end else if (go_back) begin
                    // Entry runs high-to-low, so "previous" is the next higher chunk.
                    if (chunk_q != TOP_CHUNK) begin
                        chunk_d = chunk_q + 1'b1;
                    end else if (op_q != '0) begin
                        op_d    = op_q - 1'b1;
                        chunk_d = '0;
                    end
                end
            end
            S_CONF: begin
                if (go_next) begin
                    conf_d      = sw[CONF_W-1:0];
                    timer_d     = '0;
                    alu_start_d = 1'b1;
                    state_d     = S_EXEC;
                end else if (go_back) begin
                    state_d = S_LOAD;
                    op_d    = LAST_OP;
                    chunk_d = '0;
                end
            end
            S_EXEC: begin
                // A done arriving on the timeout cycle still counts as success.
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = S_RESULT;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESULT, S_ERR: begin
                if (go_next) state_d = S_READY;
            end
            default: state_d = S_OFF;
        endcase
    end

    assign page_data = result_q[int'(page_q)*SW_W +: SW_W];
    assign page_nib  = 16'(page_data);
    assign load_tag  = (CHUNKS == 2) ? (chunk_q[0] ? CHAR_H : CHAR_L) : 5'(chunk_q);

    always_comb begin
        led         = '0;
        show_result = 1'b0;
        disp        = {4{CHAR_BLANK}};
        case (state_q)
            S_OFF:    disp = {CHAR_0, CHAR_F, CHAR_F, CHAR_BLANK};
            S_LOAD:   disp = {CHAR_L, CHAR_D, CHAR_A + 5'(op_q), load_tag};
            S_CONF:   disp = {CHAR_C, CHAR_0, CHAR_N, CHAR_F};
            S_RESULT: begin
                show_result = 1'b1;
                led         = page_data;
                disp        = {1'b0, page_nib[15:12], 1'b0, page_nib[11:8],
                               1'b0, page_nib[7:4],   1'b0, page_nib[3:0]};
            end
            S_ERR:    disp = {CHAR_E, CHAR_R, CHAR_R, CHAR_BLANK};
            default:  disp = {4{CHAR_BLANK}};
        endcase
    end

    assign ops       = ops_q;
    assign conf      = conf_q;
    assign alu_start = alu_start_q;
    assign busy      = (state_q == S_EXEC);

endmodule

// File: tb/tb_op_entry_sequencer.sv
// Directed testbench for op_entry_sequencer. Two instances share clock,
// reset, buttons and switches: dut0 is the 32-bit / 2-operand build with a
// short timeout, dut1 the 64-bit / 3-operand build. Each scenario resets both
// and checks only the instance it targets.
module tb_op_entry_sequencer;
    import op_entry_sequencer_pkg::*;

    logic         clk, rst_n, btn_next, btn_back;
    logic [15:0]  sw;
    logic         alu_done0, alu_done1;
    logic [31:0]  alu_result0;
    logic [63:0]  alu_result1;
    logic [63:0]  ops0;
    logic [191:0] ops1;
    logic [3:0]   conf0, conf1;
    logic         alu_start0, alu_start1, show0, show1, busy0, busy1;
    logic [15:0]  led0, led1;
    logic [19:0]  disp0, disp1;

    int n_tests = 0;
    int n_fail  = 0;

    op_entry_sequencer #(.DATA_W(32), .SW_W(16), .N_OPS(2), .CONF_W(4), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_back(btn_back), .sw(sw),
        .alu_done(alu_done0), .alu_result(alu_result0), .ops(ops0), .conf(conf0),
        .alu_start(alu_start0), .led(led0), .disp(disp0), .show_result(show0), .busy(busy0));

    op_entry_sequencer #(.DATA_W(64), .SW_W(16), .N_OPS(3), .CONF_W(4), .TIMEOUT(1024)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_back(btn_back), .sw(sw),
        .alu_done(alu_done1), .alu_result(alu_result1), .ops(ops1), .conf(conf1),
        .alu_start(alu_start1), .led(led1), .disp(disp1), .show_result(show1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] d4(input logic [4:0] c3, input logic [4:0] c2,
                                       input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one button pulse around a single rising edge; returns at the
    // following falling edge with the result of that edge visible.
    task automatic press(input logic nx, input logic bk, input logic [15:0] s);
        sw = s; btn_next = nx; btn_back = bk;
        @(negedge clk);
        btn_next = 1'b0; btn_back = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enter A and B on dut0 (two chunks each) and stop in CONF.
    task automatic load_two(input logic [31:0] a, input logic [31:0] b);
        press(1, 0, 16'h0);
        press(1, 0, a[31:16]); press(1, 0, a[15:0]);
        press(1, 0, b[31:16]); press(1, 0, b[15:0]);
    endtask

    logic [19:0]  BLANK4, OFF4, CONF4, ERR4;
    logic [191:0] exp_ops1;
    logic [15:0]  v;

    initial begin
        rst_n = 1'b1; btn_next = 0; btn_back = 0; sw = '0;
        alu_done0 = 0; alu_done1 = 0; alu_result0 = '0; alu_result1 = '0;
        BLANK4 = d4(CHAR_BLANK, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK);
        OFF4   = d4(CHAR_0, CHAR_F, CHAR_F, CHAR_BLANK);
        CONF4  = d4(CHAR_C, CHAR_0, CHAR_N, CHAR_F);
        ERR4   = d4(CHAR_E, CHAR_R, CHAR_R, CHAR_BLANK);

        // 1. reset defaults, 2.0 + 3.0 flow
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_disp", 192'(disp0), 192'(OFF4));
        chk("rst_outs", 192'({led0, show0, busy0, alu_start0, conf0}), 192'(0));
        chk("rst_ops",  192'(ops0), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        press(1, 0, 16'h0);
        chk("load_AH", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, CHAR_A, CHAR_H)));
        press(1, 0, 16'h4000);
        chk("load_AL", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, CHAR_A, CHAR_L)));
        press(1, 0, 16'h0000);
        chk("load_bH", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, 5'h0B, CHAR_H)));
        press(1, 0, 16'h4040);
        press(1, 0, 16'h0000);
        chk("conf_disp", 192'(disp0), 192'(CONF4));
        chk("ops_2_3", 192'(ops0), 192'(64'h40400000_40000000));
        press(1, 0, 16'h0008);
        chk("exec_state", 192'({busy0, alu_start0, conf0, disp0}), 192'({2'b11, 4'b1000, BLANK4}));
        alu_done0 = 1'b1; alu_result0 = 32'h40A00000;
        tick(1);
        alu_done0 = 1'b0;
        chk("res_page0", 192'({show0, led0, disp0}), 192'({1'b1, 16'h0000, d4(0, 0, 0, 0)}));
        sw = 16'h8000;
        tick(1);
        chk("res_page1", 192'({led0, disp0}), 192'({16'h40A0, d4(5'h04, 5'h00, 5'h0A, 5'h00)}));
        press(1, 0, 16'h8000);
        chk("ready", 192'({led0, show0, disp0}), 192'({17'h0, BLANK4}));
        press(1, 0, 16'h0);
        chk("reload_AH", 192'({ops0, disp0}), 192'({64'h40400000_40000000, d4(CHAR_L, CHAR_D, CHAR_A, CHAR_H)}));

        // 2. back-step
        do_reset();
        press(1, 0, 16'h0);
        press(0, 1, 16'h0);
        chk("back_top", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, CHAR_A, CHAR_H)));
        press(1, 0, 16'h1234);
        press(0, 1, 16'h0);
        chk("back_AH", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, CHAR_A, CHAR_H)));
        press(1, 0, 16'h5678);
        press(1, 0, 16'h0000);
        chk("back_opsA", 192'(ops0[31:0]), 192'(32'h56780000));
        press(0, 1, 16'h0);
        chk("back_cross", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, CHAR_A, CHAR_L)));
        press(1, 0, 16'h0000);
        press(1, 0, 16'h1111); press(1, 0, 16'h2222);
        press(0, 1, 16'h0);
        chk("conf_back", 192'(disp0), 192'(d4(CHAR_L, CHAR_D, 5'h0B, CHAR_L)));

        // 3. timeout
        do_reset();
        load_two(32'h1, 32'h2);
        press(1, 0, 16'h0);
        tick(15);
        chk("to_still_busy", 192'({busy0, disp0}), 192'({1'b1, BLANK4}));
        tick(1);
        chk("to_err", 192'({busy0, led0, disp0}), 192'({17'h0, ERR4}));
        press(1, 0, 16'h0);
        chk("err_ready", 192'(disp0), 192'(BLANK4));

        // 6. done on the timeout cycle wins; start pulse width
        do_reset();
        load_two(32'h3, 32'h4);
        press(1, 0, 16'h0008);
        chk("start_hi", 192'(alu_start0), 192'(1));
        tick(1);
        chk("start_lo", 192'(alu_start0), 192'(0));
        tick(14);
        alu_done0 = 1'b1; alu_result0 = 32'h12345678;
        tick(1);
        alu_done0 = 1'b0;
        chk("done_vs_to", 192'({show0, led0}), 192'({1'b1, 16'h5678}));
        alu_done0 = 1'b1; alu_result0 = 32'hDEADBEEF;
        tick(1);
        alu_done0 = 1'b0;
        chk("done_ignored", 192'(led0), 192'(16'h5678));

        // 5. reset mid-EXEC / mid-LOAD; same-cycle next+back
        do_reset();
        load_two(32'hAAAA5555, 32'h0F0F0F0F);
        press(1, 0, 16'h0);
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exec", 192'({busy0, disp0, ops0}), 192'({1'b0, OFF4, 64'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        press(1, 0, 16'h0);
        press(1, 0, 16'hABCD);
        press(1, 1, 16'h9999);
        chk("both_btns", 192'({disp0, ops0}), 192'({d4(CHAR_L, CHAR_D, CHAR_A, CHAR_L), 64'h00000000_ABCD0000}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_load", 192'({disp0, ops0}), 192'({OFF4, 64'h0}));
        @(negedge clk);
        rst_n = 1'b1;

        // 4. 64-bit, three operands
        do_reset();
        exp_ops1 = '0;
        press(1, 0, 16'h0);
        for (int op = 0; op < 3; op++) begin
            for (int ch = 3; ch >= 0; ch--) begin
                chk($sformatf("w64_tag_%0d_%0d", op, ch), 192'(disp1),
                    192'(d4(CHAR_L, CHAR_D, 5'(10 + op), 5'(ch))));
                v = 16'(16'h1000 * (op + 1) + 16'h0010 * ch + 16'h0005);
                exp_ops1[op*64 + ch*16 +: 16] = v;
                press(1, 0, v);
            end
        end
        chk("w64_conf", 192'(disp1), 192'(CONF4));
        chk("w64_ops", ops1, exp_ops1);
        press(1, 0, 16'h0);
        alu_done1 = 1'b1; alu_result1 = 64'h1111_2222_3333_4444;
        tick(1);
        alu_done1 = 1'b0;
        sw = 16'h8000;
        tick(1);
        chk("w64_page2", 192'({led1, disp1}), 192'({16'h2222, d4(5'h02, 5'h02, 5'h02, 5'h02)}));
        sw = 16'hC000;
        tick(1);
        chk("w64_page3", 192'(led1), 192'(16'h1111));
        sw = 16'h4000;
        tick(1);
        chk("w64_page1", 192'(led1), 192'(16'h3333));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
